// File: rtl/soc_vga_pkg.sv
// VGA scanout shared definitions: 640x480@60 timing defaults, pixel formats,
// per-pixel pipeline flags and the RGB332 -> 4:4:4 expansion.
package soc_vga_pkg;

  localparam int unsigned VGA_H_VISIBLE = 640;
  localparam int unsigned VGA_H_FP      = 16;
  localparam int unsigned VGA_H_SYNC    = 96;
  localparam int unsigned VGA_H_BP      = 48;
  localparam int unsigned VGA_V_VISIBLE = 480;
  localparam int unsigned VGA_V_FP      = 10;
  localparam int unsigned VGA_V_SYNC    = 2;
  localparam int unsigned VGA_V_BP      = 33;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-pixel flags travelling alongside the framebuffer read
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
    logic fs;
  } pix_flags_t;

  function automatic rgb444_t rgb332_to_444(input rgb332_t p);
    rgb444_t o;
    o.r = {p.r, p.r[2]};
    o.g = {p.g, p.g[2]};
    o.b = {p.b, p.b};
    return o;
  endfunction

endpackage

// File: rtl/soc_vga_scanout_if.sv
// Framebuffer read port (port B) as seen by the scanout engine.
interface soc_vga_scanout_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] fb_addr;
  logic [7:0]            fb_data;

  modport master (output fb_addr, input fb_data);
  modport slave  (input fb_addr, output fb_data);
endinterface

// File: rtl/soc_vga_timing.sv
// VGA raster counters and sync/visible/frame-boundary decode.
module soc_vga_timing
  import soc_vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = VGA_H_VISIBLE,
  parameter int unsigned H_FP      = VGA_H_FP,
  parameter int unsigned H_SYNC    = VGA_H_SYNC,
  parameter int unsigned H_BP      = VGA_H_BP,
  parameter int unsigned V_VISIBLE = VGA_V_VISIBLE,
  parameter int unsigned V_FP      = VGA_V_FP,
  parameter int unsigned V_SYNC    = VGA_V_SYNC,
  parameter int unsigned V_BP      = VGA_V_BP,
  parameter int unsigned H_CNT_W   = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP),
  parameter int unsigned V_CNT_W   = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP)
) (
  input  logic               vga_clk,
  input  logic               res,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               visible,
  output logic               hsync_act,
  output logic               vsync_act,
  output logic               frame_end
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  logic [H_CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic               h_last;

  assign h_last = (h_cnt_q == H_CNT_W'(H_TOTAL - 1));

  // Advance the raster position, wrapping line then frame
  always_comb begin
    h_cnt_d = h_cnt_q + H_CNT_W'(1);
    v_cnt_d = v_cnt_q;
    if (h_last) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + V_CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge vga_clk) begin
    if (!res) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_cnt     = h_cnt_q;
  assign v_cnt     = v_cnt_q;
  assign visible   = (h_cnt_q < H_CNT_W'(H_VISIBLE)) && (v_cnt_q < V_CNT_W'(V_VISIBLE));
  assign hsync_act = (h_cnt_q >= H_CNT_W'(H_VISIBLE + H_FP)) &&
                     (h_cnt_q <  H_CNT_W'(H_VISIBLE + H_FP + H_SYNC));
  assign vsync_act = (v_cnt_q >= V_CNT_W'(V_VISIBLE + V_FP)) &&
                     (v_cnt_q <  V_CNT_W'(V_VISIBLE + V_FP + V_SYNC));
  assign frame_end = h_last && (v_cnt_q == V_CNT_W'(V_TOTAL - 1));

endmodule

// File: rtl/soc_vga_scanout.sv
// VGA scanout: fetches one RGB332 byte per visible pixel from the framebuffer,
// aligns sync/enable with the read latency and drives registered VGA pins.
// Optional macro SOC_VGA_DOUBLE_SCAN_EN: 2x2 pixel replication from a
// half-resolution source image.
module soc_vga_scanout
  import soc_vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = VGA_H_VISIBLE,
  parameter int unsigned H_FP       = VGA_H_FP,
  parameter int unsigned H_SYNC     = VGA_H_SYNC,
  parameter int unsigned H_BP       = VGA_H_BP,
  parameter int unsigned V_VISIBLE  = VGA_V_VISIBLE,
  parameter int unsigned V_FP       = VGA_V_FP,
  parameter int unsigned V_SYNC     = VGA_V_SYNC,
  parameter int unsigned V_BP       = VGA_V_BP,
  parameter logic        HS_ACTIVE  = 1'b0,
  parameter logic        VS_ACTIVE  = 1'b0,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned FB_LATENCY = 1
) (
  input  logic                  vga_clk,
  input  logic                  res,
  input  logic                  scan_en,
  input  logic [ADDR_WIDTH-1:0] fb_base,
  soc_vga_scanout_if.master     fb,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  frame_start
);

  localparam int unsigned H_CNT_W = $clog2(H_VISIBLE + H_FP + H_SYNC + H_BP);
  localparam int unsigned V_CNT_W = $clog2(V_VISIBLE + V_FP + V_SYNC + V_BP);

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               visible, hsync_act, vsync_act, frame_end;

  soc_vga_timing #(
    .H_VISIBLE (H_VISIBLE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VISIBLE (V_VISIBLE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .H_CNT_W   (H_CNT_W),   .V_CNT_W (V_CNT_W)
  ) u_timing (
    .vga_clk   (vga_clk),
    .res       (res),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .visible   (visible),
    .hsync_act (hsync_act),
    .vsync_act (vsync_act),
    .frame_end (frame_end)
  );

  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                  first_q, first_d;
`ifdef SOC_VGA_DOUBLE_SCAN_EN
  logic [ADDR_WIDTH-1:0] line_base_q, line_base_d;
`endif

  // Address pointer: reload at frame boundary, step on visible pixels
  always_comb begin
    ptr_d     = ptr_q;
    fb_addr_d = fb_addr_q;
    first_d   = first_q;
`ifdef SOC_VGA_DOUBLE_SCAN_EN
    line_base_d = line_base_q;
`endif
    if (frame_end) begin
      ptr_d   = fb_base;
      first_d = 1'b0;
`ifdef SOC_VGA_DOUBLE_SCAN_EN
      line_base_d = fb_base;
`endif
    end else if (visible) begin
      fb_addr_d = ptr_q;
`ifdef SOC_VGA_DOUBLE_SCAN_EN
      // Even lines replay from line_base; odd lines move on to the next source row
      if (h_cnt == H_CNT_W'(H_VISIBLE - 1)) begin
        if (!v_cnt[0]) begin
          ptr_d = line_base_q;
        end else begin
          ptr_d       = ptr_q + ADDR_WIDTH'(1);
          line_base_d = ptr_q + ADDR_WIDTH'(1);
        end
      end else if (h_cnt[0]) begin
        ptr_d = ptr_q + ADDR_WIDTH'(1);
      end
`else
      ptr_d = ptr_q + ADDR_WIDTH'(1);
`endif
    end
  end

  pix_flags_t stage0;
  pix_flags_t pipe_q [FB_LATENCY+1];
  pix_flags_t pipe_d [FB_LATENCY+1];

  // Flags captured alongside the address, then delayed to meet the read data
  always_comb begin
    stage0.de = visible && scan_en;
    stage0.hs = hsync_act;
    stage0.vs = vsync_act;
    stage0.fs = (h_cnt == '0) && (v_cnt == '0) && !first_q;
    pipe_d[0] = stage0;
    for (int unsigned i = 1; i <= FB_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  logic    hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  rgb444_t rgb_q, rgb_d;

  // Output stage: colour expansion and sync polarity
  always_comb begin
    hs_d  = pipe_q[FB_LATENCY].hs ? HS_ACTIVE : ~HS_ACTIVE;
    vs_d  = pipe_q[FB_LATENCY].vs ? VS_ACTIVE : ~VS_ACTIVE;
    fs_d  = pipe_q[FB_LATENCY].fs;
    rgb_d = pipe_q[FB_LATENCY].de ? rgb332_to_444(rgb332_t'(fb.fb_data)) : '0;
  end

  // All state registers
  always_ff @(posedge vga_clk) begin
    if (!res) begin
      ptr_q     <= '0;
      fb_addr_q <= '0;
      first_q   <= 1'b1;
`ifdef SOC_VGA_DOUBLE_SCAN_EN
      line_base_q <= '0;
`endif
      for (int unsigned i = 0; i <= FB_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      hs_q  <= ~HS_ACTIVE;
      vs_q  <= ~VS_ACTIVE;
      fs_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      fb_addr_q <= fb_addr_d;
      first_q   <= first_d;
`ifdef SOC_VGA_DOUBLE_SCAN_EN
      line_base_q <= line_base_d;
`endif
      for (int unsigned i = 0; i <= FB_LATENCY; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      fs_q  <= fs_d;
      rgb_q <= rgb_d;
    end
  end

  assign fb.fb_addr  = fb_addr_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_r       = rgb_q.r;
  assign vga_g       = rgb_q.g;
  assign vga_b       = rgb_q.b;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_soc_vga_scanout.sv
// Bench for soc_vga_scanout: two instances (read latency 1 and 2) on a reduced
// raster, compared every cycle against a position-based reference model.
module tb_soc_vga_scanout;

  localparam int HV = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VV = 8,  VFP = 1, VSY = 2, VBP = 2;
  localparam int HT = HV + HFP + HSY + HBP;
  localparam int VT = VV + VFP + VSY + VBP;
  localparam int FT = HT * VT;
  localparam int HIST = 4096;

  logic        clk = 1'b0;
  logic        res;
  logic        scan_en;
  logic [31:0] fb_base;

  always #5 clk = ~clk;

  soc_vga_scanout_if #(.ADDR_WIDTH(32)) fb1 ();
  soc_vga_scanout_if #(.ADDR_WIDTH(32)) fb2 ();

  logic       hs1, vs1, fs1, hs2, vs2, fs2;
  logic [3:0] r1, g1, b1, r2, g2, b2;

  soc_vga_scanout #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0), .ADDR_WIDTH(32), .FB_LATENCY(1)
  ) dut1 (
    .vga_clk(clk), .res(res), .scan_en(scan_en), .fb_base(fb_base), .fb(fb1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .frame_start(fs1)
  );

  soc_vga_scanout #(
    .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_ACTIVE(1'b0), .VS_ACTIVE(1'b0), .ADDR_WIDTH(32), .FB_LATENCY(2)
  ) dut2 (
    .vga_clk(clk), .res(res), .scan_en(scan_en), .fb_base(fb_base), .fb(fb2),
    .vga_hs(hs2), .vga_vs(vs2), .vga_r(r2), .vga_g(g2), .vga_b(b2), .frame_start(fs2)
  );

  // Framebuffer contents: byte at address a is a[7:0]^0x5A
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] rd1_q;
  logic [7:0] rd2_q [2];
  always @(posedge clk) begin
    rd1_q    <= mem_byte(fb1.fb_addr);
    rd2_q[0] <= mem_byte(fb2.fb_addr);
    rd2_q[1] <= rd2_q[0];
  end
  assign fb1.fb_data = rd1_q;
  assign fb2.fb_data = rd2_q[1];

  int          total = 0;
  int          bad = 0;
  int          n = 0;
  logic        en_hist [HIST];
  logic [31:0] base_in [HIST];
  logic [31:0] last_addr = '0;

  // Address of the pixel shown at raster cycle p since reset
  function automatic logic [31:0] pix_addr(input int p);
    int h, v, f;
    logic [31:0] b;
    h = p % HT;
    v = (p / HT) % VT;
    f = p / FT;
    b = (f == 0) ? 32'd0 : base_in[f*FT-1];
`ifdef SOC_VGA_DOUBLE_SCAN_EN
    return b + 32'((v / 2) * (HV / 2) + h / 2);
`else
    return b + 32'(v * HV + h);
`endif
  endfunction

  function automatic bit is_vis(input int p);
    return ((p % HT) < HV) && (((p / HT) % VT) < VV);
  endfunction

  task automatic cmp(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", name, n, obs, exp);
    end
  endtask

  task automatic check_pins(input string tag, input int lat, input logic hs, input logic vs,
                            input logic [11:0] rgb, input logic fs);
    int p, h, v, f;
    logic ehs, evs, efs;
    logic [11:0] ergb;
    logic [31:0] a;
    logic [7:0] d;
    p = n - lat - 2;
    ehs = 1'b1; evs = 1'b1; efs = 1'b0; ergb = '0;
    if (p >= 0) begin
      h = p % HT; v = (p / HT) % VT; f = p / FT;
      ehs = !(h >= HV + HFP && h < HV + HFP + HSY);
      evs = !(v >= VV + VFP && v < VV + VFP + VSY);
      efs = (h == 0) && (v == 0) && (f > 0);
      if (h < HV && v < VV && en_hist[p]) begin
        a = pix_addr(p);
        d = mem_byte(a);
        ergb = {d[7:5], d[7], d[4:2], d[4], d[1:0], d[1:0]};
      end
    end
    cmp({tag, "_hs"},  32'(hs),  32'(ehs));
    cmp({tag, "_vs"},  32'(vs),  32'(evs));
    cmp({tag, "_rgb"}, 32'(rgb), 32'(ergb));
    cmp({tag, "_fs"},  32'(fs),  32'(efs));
  endtask

  task automatic check_all();
    cmp("l1_addr", fb1.fb_addr, last_addr);
    cmp("l2_addr", fb2.fb_addr, last_addr);
    check_pins("l1", 1, hs1, vs1, {r1, g1, b1}, fs1);
    check_pins("l2", 2, hs2, vs2, {r2, g2, b2}, fs2);
  endtask

  // One clock: log this cycle's inputs, advance, then check the new state
  task automatic step();
    if (res) begin
      en_hist[n] = scan_en;
      base_in[n] = fb_base;
    end
    @(posedge clk);
    #1;
    if (!res) begin
      n = 0;
      last_addr = '0;
    end else begin
      if (is_vis(n)) last_addr = pix_addr(n);
      n++;
    end
    check_all();
  endtask

  task automatic rand_inputs();
    int h;
    h = n % HT;
    if (h == 0) scan_en = ($urandom_range(0, 3) != 0);
    else if ($urandom_range(0, 31) == 0) scan_en = ~scan_en;
    if ($urandom_range(0, 99) == 0) begin
      case ($urandom_range(0, 2))
        0:       fb_base = $urandom;
        1:       fb_base = 32'hFFFF_FFC0;
        default: fb_base = {$urandom_range(0, 255), 8'h00};
      endcase
    end
  endtask

  initial begin
    int h, v, f;
    res = 1'b0; scan_en = 1'b1; fb_base = '0;

    // Reset hold
    repeat (5) step();

    // Directed frames: base 0x1000, switch mid-frame, one blanked line
    res = 1'b1;
    fb_base = 32'h1000;
    while (n < 3 * FT) begin
      h = n % HT; v = (n / HT) % VT; f = n / FT;
      if (f == 1 && v == 2 && h == 0) fb_base = 32'h80000;
      scan_en = !(f == 2 && v == 3);
      step();
    end

    // Randomized enable and base changes
    while (n < 7 * FT) begin
      rand_inputs();
      step();
    end

    // Reset mid-frame, then run on from (0,0)
    while (n < 7 * FT + 100) begin
      rand_inputs();
      step();
    end
    res = 1'b0;
    repeat (3) step();
    res = 1'b1;
    while (n < 2 * FT + 50) begin
      rand_inputs();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
